// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame FSM states,
// scan-code prefixes, the key translation table and frame-check helpers.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  localparam logic [7:0] PREFIX_BREAK = 8'hF0;
  localparam logic [7:0] PREFIX_EXT   = 8'hE0;

  localparam int NUM_KEYS = 8;

  // Set-2 make codes for A, D, W, S, J, L, I, K and their translated codes (same order)
  localparam logic [NUM_KEYS-1:0][7:0] SCAN_CODES =
    {8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h3B, 8'h4B, 8'h43, 8'h42};
  localparam logic [NUM_KEYS-1:0][7:0] KEY_CODES =
    {8'h41, 8'h44, 8'h57, 8'h53, 8'h4A, 8'h4C, 8'h49, 8'h4B};

  typedef struct packed {
    logic       hit;
    logic [7:0] code;
  } key_xlat_t;

  function automatic key_xlat_t translate(input logic [7:0] scan);
    key_xlat_t res;
    res.hit  = 1'b0;
    res.code = 8'h00;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (SCAN_CODES[i] == scan) begin
        res.hit  = 1'b1;
        res.code = KEY_CODES[i];
      end
    end
    return res;
  endfunction

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the device lines, deserialises 11-bit frames,
// checks odd parity and the stop bit, and abandons frames that stall.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic           clk_meta_r, clk_sync_r, clk_prev_r;
  logic           dat_meta_r, dat_sync_r;
  frame_state_t   state_r;
  logic [2:0]     bit_cnt_r;
  logic [7:0]     shift_r;
  logic           parity_r;
  logic [TW-1:0]  tmo_cnt_r;
  logic           fall_s, stop_edge_s, good_s, timeout_s;

  // Two-flop synchronisers plus a delayed clock copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      clk_prev_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= ps2_clk;
      clk_sync_r <= clk_meta_r;
      clk_prev_r <= clk_sync_r;
      dat_meta_r <= ps2_dat;
      dat_sync_r <= dat_meta_r;
    end
  end

  assign fall_s      = clk_prev_r & ~clk_sync_r;
  assign stop_edge_s = fall_s && (state_r == ST_STOP);
  assign good_s      = dat_sync_r && odd_parity_ok(shift_r, parity_r);
  assign timeout_s   = (state_r != ST_IDLE) && !fall_s && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));

  assign rx_byte    = shift_r;
  assign byte_valid = stop_edge_s & good_s;
  assign frame_err  = (stop_edge_s & ~good_s) | timeout_s;

  // Frame FSM: one state step per PS2_CLK falling edge; stalled frames fall back to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      tmo_cnt_r <= '0;
    end else if (fall_s) begin
      tmo_cnt_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (!dat_sync_r) begin
            state_r   <= ST_DATA;
            bit_cnt_r <= 3'd0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_r   <= {dat_sync_r, shift_r[7:1]};
          bit_cnt_r <= bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_r <= ST_PARITY;
          end else begin
            state_r <= ST_DATA;
          end
        end
        ST_PARITY: begin
          parity_r <= dat_sync_r;
          state_r  <= ST_STOP;
        end
        ST_STOP: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end else if (timeout_s) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      tmo_cnt_r <= '0;
    end else if (state_r != ST_IDLE) begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard front end: decodes F0/E0 prefixes, translates a small key set,
// holds the currently pressed key and pulses a buzzer on each new press.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int BUZZ_CYCLES    = 2500000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] PS2_DATA,
  output logic       BUZZER_EN,
  output logic       FRAME_ERR
);

  localparam int BW = $clog2(BUZZ_CYCLES + 1);

  logic [7:0]    rx_byte_s;
  logic          byte_valid_s, frame_err_s;
  logic          brk_r, ext_r;
  logic [BW-1:0] buzz_cnt_r;
  key_xlat_t     xlat_s;
  logic          key_hit_s, make_new_s, release_s;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk       (CLK),
    .rst       (RST),
    .ps2_clk   (PS2_CLK),
    .ps2_dat   (PS2_DAT),
    .rx_byte   (rx_byte_s),
    .byte_valid(byte_valid_s),
    .frame_err (frame_err_s)
  );

  // Extended-prefixed codes are never translated, make or break
  assign xlat_s     = translate(rx_byte_s);
  assign key_hit_s  = byte_valid_s && !ext_r && xlat_s.hit;
  assign make_new_s = key_hit_s && !brk_r && (PS2_DATA != xlat_s.code);
  assign release_s  = key_hit_s && brk_r && (PS2_DATA == xlat_s.code);

  // Prefix flags live until the next non-prefix byte or a discarded frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      brk_r     <= 1'b0;
      ext_r     <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_ERR <= frame_err_s;
      if (frame_err_s) begin
        brk_r <= 1'b0;
        ext_r <= 1'b0;
      end else if (byte_valid_s) begin
        if (rx_byte_s == PREFIX_BREAK) begin
          brk_r <= 1'b1;
        end else if (rx_byte_s == PREFIX_EXT) begin
          ext_r <= 1'b1;
        end else begin
          brk_r <= 1'b0;
          ext_r <= 1'b0;
        end
      end else begin
        brk_r <= brk_r;
        ext_r <= ext_r;
      end
    end
  end

  // Held-key register and buzzer pulse; a repeat of the held key does not retrigger
  always_ff @(posedge CLK) begin
    if (RST) begin
      PS2_DATA   <= 8'h00;
      buzz_cnt_r <= '0;
      BUZZER_EN  <= 1'b0;
    end else begin
      if (make_new_s) begin
        PS2_DATA <= xlat_s.code;
      end else if (release_s) begin
        PS2_DATA <= 8'h00;
      end else begin
        PS2_DATA <= PS2_DATA;
      end
      if (make_new_s) begin
        buzz_cnt_r <= BW'(BUZZ_CYCLES);
        BUZZER_EN  <= 1'b1;
      end else if (buzz_cnt_r != BW'(0)) begin
        buzz_cnt_r <= buzz_cnt_r - BW'(1);
        BUZZER_EN  <= (buzz_cnt_r > BW'(1));
      end else begin
        buzz_cnt_r <= buzz_cnt_r;
        BUZZER_EN  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed and randomised PS/2 frames checked against a byte-level keyboard model.
module tb_ps2_key_receiver;

  localparam int TMO  = 200;
  localparam int BUZZ = 100;
  localparam int HALF = 20;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [7:0] PS2_DATA;
  logic       BUZZER_EN;
  logic       FRAME_ERR;

  int vectors = 0, miscompares = 0;
  int cyc = 0, err_pulses = 0, err_long = 0, err_cyc = 0;
  int buzz_starts = 0, buzz_run = 0, last_buzz_len = 0;
  logic fe_prev = 1'b0, bz_prev = 1'b0;
  logic [7:0] pre_val, post_val;
  int edge_cyc;

  logic [7:0] scans [8] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h3B, 8'h4B, 8'h43, 8'h42};
  logic [7:0] codes [8] = '{8'h41, 8'h44, 8'h57, 8'h53, 8'h4A, 8'h4C, 8'h49, 8'h4B};
  logic [7:0] keymap [logic [7:0]];
  logic [7:0] m_key;
  bit         m_brk, m_ext;
  int         m_buzz;

  ps2_key_receiver #(.TIMEOUT_CYCLES(TMO), .BUZZ_CYCLES(BUZZ)) dut (
    .CLK(CLK), .RST(RST), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .PS2_DATA(PS2_DATA), .BUZZER_EN(BUZZER_EN), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor for FRAME_ERR and BUZZER_EN, sampled away from the active edge
  always @(negedge CLK) begin
    fe_prev <= FRAME_ERR;
    bz_prev <= BUZZER_EN;
    if (FRAME_ERR === 1'b1 && fe_prev === 1'b1) err_long <= err_long + 1;
    if (FRAME_ERR === 1'b1 && fe_prev !== 1'b1) begin
      err_pulses <= err_pulses + 1;
      err_cyc    <= cyc;
    end
    if (BUZZER_EN === 1'b1 && bz_prev !== 1'b1) begin
      buzz_starts <= buzz_starts + 1;
      buzz_run    <= 1;
    end else if (BUZZER_EN === 1'b1) begin
      buzz_run <= buzz_run + 1;
    end
    if (BUZZER_EN !== 1'b1 && bz_prev === 1'b1) last_buzz_len <= buzz_run;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Keyboard behaviour at byte level: prefixes, translation, hold and buzzer triggers
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (!m_ext && keymap.exists(b)) begin
        if (!m_brk) begin
          if (m_key != keymap[b]) begin
            m_key = keymap[b];
            m_buzz++;
          end
        end else if (m_key == keymap[b]) begin
          m_key = 8'h00;
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_key = 8'h00; m_brk = 1'b0; m_ext = 1'b0;
  endtask

  // One PS/2 bit: data set while clock is high, then a low half-period
  task automatic ps2_edge(input logic bitv, input bit last);
    PS2_DAT = bitv;
    repeat (HALF) @(posedge CLK);
    #1 PS2_CLK = 1'b0;
    edge_cyc = cyc;
    if (last) begin
      repeat (2) @(posedge CLK);
      @(negedge CLK) pre_val = PS2_DATA;
      @(posedge CLK);
      @(negedge CLK) post_val = PS2_DATA;
      repeat (HALF - 3) @(posedge CLK);
    end else begin
      repeat (HALF) @(posedge CLK);
    end
    #1 PS2_CLK = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_edge(f[i], i == 10);
    PS2_DAT = 1'b1;
  endtask

  task automatic send_and_check(input string tag, input logic [7:0] b, input bit bad);
    logic [7:0] old_key;
    int e0, b0, mb0;
    old_key = m_key; e0 = err_pulses; b0 = buzz_starts; mb0 = m_buzz;
    send_bits(make_frame(b, bad), 11);
    if (bad) begin m_brk = 1'b0; m_ext = 1'b0; end
    else model_byte(b);
    check({tag, "_pre"}, {24'h0, pre_val}, {24'h0, old_key});
    check({tag, "_post"}, {24'h0, post_val}, {24'h0, m_key});
    check({tag, "_err"}, err_pulses - e0, {31'h0, bad});
    check({tag, "_buzz"}, buzz_starts - b0, m_buzz - mb0);
  endtask

  initial begin
    int e0, d, r;
    logic [7:0] b;
    bit bad;
    for (int i = 0; i < 8; i++) keymap[scans[i]] = codes[i];
    model_reset();
    m_buzz = 0;

    repeat (5) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_data", {24'h0, PS2_DATA}, 32'h0);
    check("rst_buzz", {31'h0, BUZZER_EN}, 32'h0);
    check("rst_err", {31'h0, FRAME_ERR}, 32'h0);

    // Single key press, buzzer length
    send_and_check("a_press", 8'h1C, 1'b0);
    check("a_code", {24'h0, post_val}, 32'h41);
    repeat (BUZZ + 20) @(posedge CLK);
    check("buzz_len", last_buzz_len, BUZZ);

    // Last pressed wins; release of a non-held key is ignored
    send_and_check("w_press", 8'h1D, 1'b0);
    check("w_code", {24'h0, post_val}, 32'h57);
    send_and_check("d_press", 8'h23, 1'b0);
    check("d_code", {24'h0, post_val}, 32'h44);
    send_and_check("w_brk_f0", 8'hF0, 1'b0);
    send_and_check("w_brk", 8'h1D, 1'b0);
    check("w_brk_hold", {24'h0, post_val}, 32'h44);
    send_and_check("d_brk_f0", 8'hF0, 1'b0);
    send_and_check("d_brk", 8'h23, 1'b0);
    check("d_brk_clr", {24'h0, post_val}, 32'h00);

    // Bad parity frame
    send_and_check("bad_par", 8'h1C, 1'b1);
    check("bad_par_data", {24'h0, PS2_DATA}, 32'h00);
    check("bad_par_width", err_long, 0);

    // Stalled frame after 4 data bits
    e0 = err_pulses;
    send_bits(make_frame(8'h1B, 1'b0), 5);
    repeat (TMO + 20) @(posedge CLK);
    d = err_cyc - edge_cyc;
    check("tmo_pulse", err_pulses - e0, 1);
    check("tmo_time", {31'h0, (d >= TMO + 2 && d <= TMO + 4)}, 32'h1);
    repeat (3 * TMO) @(posedge CLK);
    check("tmo_idle", err_pulses - e0, 1);
    check("tmo_width", err_long, 0);
    m_brk = 1'b0; m_ext = 1'b0;
    send_and_check("s_press", 8'h1B, 1'b0);
    check("s_code", {24'h0, post_val}, 32'h53);
    send_and_check("s_brk_f0", 8'hF0, 1'b0);
    send_and_check("s_brk", 8'h1B, 1'b0);

    // Extended codes ignored
    send_and_check("e0_a", 8'hE0, 1'b0);
    send_and_check("e0_a_mk", 8'h1C, 1'b0);
    send_and_check("e0_b", 8'hE0, 1'b0);
    send_and_check("e0_b_f0", 8'hF0, 1'b0);
    send_and_check("e0_b_brk", 8'h1C, 1'b0);
    check("ext_hold", {24'h0, PS2_DATA}, 32'h00);
    send_and_check("k_press", 8'h42, 1'b0);
    check("k_code", {24'h0, post_val}, 32'h4B);

    // Reset during the 5th data bit of 3B
    send_bits(make_frame(8'h3B, 1'b0), 5);
    PS2_DAT = 1'b1;
    repeat (HALF / 2) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    model_reset();
    check("mid_rst_data", {24'h0, PS2_DATA}, 32'h0);
    check("mid_rst_buzz", {31'h0, BUZZER_EN}, 32'h0);
    check("mid_rst_err", {31'h0, FRAME_ERR}, 32'h0);
    repeat (HALF) @(posedge CLK);
    send_and_check("j_press", 8'h3B, 1'b0);
    check("j_code", {24'h0, post_val}, 32'h4A);

    // Randomised byte stream
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      bad = 1'b0;
      case (r)
        0, 1, 2, 3, 4: b = scans[$urandom_range(0, 7)];
        5: b = 8'hF0;
        6: b = 8'hE0;
        9: begin b = 8'($urandom); bad = 1'b1; end
        default: b = 8'($urandom);
      endcase
      send_and_check("rand", b, bad);
    end

    repeat (10) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
